issue_n_alloc_scoreboard: RTL and testbench
===========================================

Name: issue_n_alloc_scoreboard

Overview:
N-wide issue allocator with a register scoreboard, successor to the two-slot fetch-allocator mini-decode path. It consumes pre-decoded per-slot fields for a fetched bundle of NUM_SLOTS instructions. It tracks destinations of in-flight long-latency (load) writes in a 64-entry scoreboard (integer plus FP file), resolves intra-bundle RAW/WAW hazards, and issues the longest legal in-order prefix of the bundle each cycle. Write-back ports clear scoreboard entries.

Parameters:
NUM_SLOTS, 2, instructions per bundle (1..4); slot 0 is the primary issue.
NUM_WB_PORTS, 2, long-latency write-back clear ports.
WB_BYPASS, 1, 1 = a write-back clear is visible to hazard checks in the same cycle; 0 = visible next cycle.
CNT_W, 32, width of the stall-cycle counter.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
bundle_valid_i  in  NUM_SLOTS  per-slot instruction valid
issue_ready_i  in  1  downstream ID stage can accept
flush_i  in  1  pipeline flush; blocks issue this cycle
rs_used_i  in  3*NUM_SLOTS  rega/regb/regc used, per slot
rs_addr_i  in  18*NUM_SLOTS  6-bit {fp,idx} addrs a/b/c, per slot
rd_addr_i  in  6*NUM_SLOTS  destination {fp,idx}
rd_alu_we_i  in  NUM_SLOTS  single-cycle ALU destination write
rd_mem_we_i  in  NUM_SLOTS  load (long-latency) destination write
ra_is_dst_i  in  NUM_SLOTS  post-inc load/store: rs_a is also written (ALU timing)
pi_legal_i  in  NUM_SLOTS  op legal on primary issue
i2_legal_i  in  NUM_SLOTS  op legal on secondary issue
wb_valid_i  in  NUM_WB_PORTS  write-back clear valid
wb_addr_i  in  6*NUM_WB_PORTS  write-back register address
issue_valid_o  out  NUM_SLOTS  thermometer mask of issued slots
issue_cnt_o  out  $clog2(NUM_SLOTS+1)  number issued this cycle
sb_busy_o  out  64  scoreboard state (registered)
stall_cnt_o  out  CNT_W  cycles with valid slot 0 and zero issued, saturating

Behaviour:
- Reset (rst_n low at a clk edge): sb_busy_o=0 and stall_cnt_o=0. issue outputs are combinational and read 0 while rst_n=0. Reset mid-operation discards all pending busy bits.
- Address 6'd0 (integer x0) is never busy, never set, and never hazards. 6'd32 (f0) is a normal register.
- Effective busy view eb:
  - WB_BYPASS=1: sb_busy & ~(OR of valid wb clears).
  - WB_BYPASS=0: sb_busy.
- Slot k is "ok" when all of the following hold:
  - bundle_valid_i[k].
  - Legality: pi_legal_i[0] for k=0; i2_legal_i[k] for k>=1.
  - No used source in eb.
  - If rd_mem_we_i[k] or rd_alu_we_i[k], rd not in eb (WAW).
  - No used source or written dest equals any dest written by slots j<k. Written dests include rd and, when ra_is_dst_i, rs_a.
- issue_cnt = longest prefix 0..m-1 with every slot ok, when issue_ready_i=1 and flush_i=0; otherwise 0. Issue is strictly in order: a non-ok slot blocks all later slots. issue_valid_o[k] = (k < issue_cnt).
- Sequential update each cycle:
  - Clear sb_busy for each valid wb_addr.
  - Then set sb_busy[rd] for each issued slot with rd_mem_we_i=1 (rd≠0).
  - Set wins over clear on the same address in the same cycle.
  - Multiple wb ports hitting the same address are legal.
  - A clear of a non-busy register is a no-op.
- ALU-timed writes (rd_alu_we_i, ra_is_dst_i) are not tracked; forwarding covers them.
- stall_cnt_o increments when bundle_valid_i[0]=1, issue_cnt=0 and flush_i=0, and saturates at all-ones.
- Latency: issue decision is zero cycles (combinational from inputs and registered state). Scoreboard set/clear is visible the next cycle; a clear is visible the same cycle when WB_BYPASS=1.
- fregfile disable and Zfinx are handled upstream; the fp bit arrives already qualified.

Test Plan:
- Reset, then bundle slot0 lw x5 (mem_we), slot1 add x6,x5,x1, ready=1 -> issue_cnt=1 (RAW intra-bundle); next cycle sb_busy_o[5]=1.
- x5 busy, slot0 add x7,x5,x2 -> issue_cnt=0, stall_cnt_o increments by 1 per cycle. wb_valid=1 addr 5 with WB_BYPASS=1 -> issue_cnt=1 that same cycle; sb_busy_o[5]=0 next cycle.
- Same cycle: wb clears f3 (addr 35) while slot0 issues flw f3 -> sb_busy_o[35]=1 next cycle (set wins).
- Slot0 lw x0 and slot1 add x1,x0,x0 with x0 dest -> both issue (cnt=2); sb_busy_o stays 0.
- Slot0 with pi_legal=0 -> cnt=0 even if slot1 is legal. Slot0 post-inc lw x8,(x9!) then slot1 add x10,x9 -> cnt=1.
- flush_i=1 or issue_ready_i=0 with a fully legal bundle -> cnt=0, no scoreboard set. Assert rst_n=0 with 3 busy regs -> sb_busy_o=0 after the edge.

Source files
------------

// File: rtl/issue_n_alloc_scoreboard.sv
// N-wide in-order issue allocator with a 64-entry load-destination scoreboard.
// Issues the longest hazard-free prefix of the bundle; write-back ports clear entries.
module issue_n_alloc_scoreboard #(
   parameter int NUM_SLOTS    = 2,
   parameter int NUM_WB_PORTS = 2,
   parameter int WB_BYPASS    = 1,
   parameter int CNT_W        = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_SLOTS-1:0]             bundle_valid_i,
   input  logic                             issue_ready_i,
   input  logic                             flush_i,
   input  logic [3*NUM_SLOTS-1:0]           rs_used_i,
   input  logic [18*NUM_SLOTS-1:0]          rs_addr_i,
   input  logic [6*NUM_SLOTS-1:0]           rd_addr_i,
   input  logic [NUM_SLOTS-1:0]             rd_alu_we_i,
   input  logic [NUM_SLOTS-1:0]             rd_mem_we_i,
   input  logic [NUM_SLOTS-1:0]             ra_is_dst_i,
   input  logic [NUM_SLOTS-1:0]             pi_legal_i,
   input  logic [NUM_SLOTS-1:0]             i2_legal_i,
   input  logic [NUM_WB_PORTS-1:0]          wb_valid_i,
   input  logic [6*NUM_WB_PORTS-1:0]        wb_addr_i,
   output logic [NUM_SLOTS-1:0]             issue_valid_o,
   output logic [$clog2(NUM_SLOTS+1)-1:0]   issue_cnt_o,
   output logic [63:0]                      sb_busy_o,
   output logic [CNT_W-1:0]                 stall_cnt_o
);

   localparam int CW = $clog2(NUM_SLOTS+1);

   logic [63:0]          sb_busy;
   logic [63:0]          wb_clr;
   logic [63:0]          eb;
   logic [63:0]          prior_wr;
   logic [63:0]          set_mask;
   logic [NUM_SLOTS-1:0] slot_ok;
   logic [NUM_SLOTS-1:0] issue_mask;
   logic [CW-1:0]        cnt;
   logic [CNT_W-1:0]     stall_cnt;
   logic [5:0]           src;
   logic [5:0]           rd;
   logic [5:0]           ra;
   logic                 hit;
   logic                 run;

   always_comb begin
      wb_clr = '0;
      for (int unsigned p = 0; p < NUM_WB_PORTS; p++)
         if (wb_valid_i[p]) wb_clr[wb_addr_i[6*p +: 6]] = 1'b1;
   end

   assign eb = (WB_BYPASS != 0) ? (sb_busy & ~wb_clr) : sb_busy;

   // prior_wr accumulates every dest written by earlier slots; x0 is excluded at each check.
   always_comb begin
      prior_wr = '0;
      slot_ok  = '0;
      src      = '0;
      rd       = '0;
      ra       = '0;
      hit      = 1'b0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         hit = 1'b0;
         for (int unsigned s = 0; s < 3; s++) begin
            src = rs_addr_i[18*k + 6*s +: 6];
            if (rs_used_i[3*k + s] && src != '0 && (eb[src] || prior_wr[src])) hit = 1'b1;
         end
         rd = rd_addr_i[6*k +: 6];
         ra = rs_addr_i[18*k +: 6];
         if ((rd_alu_we_i[k] || rd_mem_we_i[k]) && rd != '0 && (eb[rd] || prior_wr[rd])) hit = 1'b1;
         if (ra_is_dst_i[k] && ra != '0 && prior_wr[ra]) hit = 1'b1;
         slot_ok[k] = bundle_valid_i[k] && ((k == 0) ? pi_legal_i[0] : i2_legal_i[k]) && !hit;
         if (rd_alu_we_i[k] || rd_mem_we_i[k]) prior_wr[rd] = 1'b1;
         if (ra_is_dst_i[k]) prior_wr[ra] = 1'b1;
      end
   end

   always_comb begin
      run        = rst_n && issue_ready_i && !flush_i;
      issue_mask = '0;
      cnt        = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
         run           = run && slot_ok[k];
         issue_mask[k] = run;
         if (run) cnt = cnt + CW'(1);
      end
   end

   always_comb begin
      set_mask = '0;
      for (int unsigned k = 0; k < NUM_SLOTS; k++)
         if (issue_mask[k] && rd_mem_we_i[k]) set_mask[rd_addr_i[6*k +: 6]] = 1'b1;
      set_mask[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sb_busy   <= '0;
         stall_cnt <= '0;
      end else begin
         // Clear first, then set, so a same-cycle set of the same register wins.
         sb_busy <= (sb_busy & ~wb_clr) | set_mask;
         if (bundle_valid_i[0] && cnt == '0 && !flush_i && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign issue_valid_o = issue_mask;
   assign issue_cnt_o   = cnt;
   assign sb_busy_o     = sb_busy;
   assign stall_cnt_o   = stall_cnt;

endmodule

// File: tb/tb_issue_n_alloc_scoreboard.sv
// Bench for issue_n_alloc_scoreboard: directed scenarios with literal expectations,
// then randomized bundles checked every cycle against a pairwise-hazard reference model.
module tb_issue_n_alloc_scoreboard;

   localparam int NS  = 2;
   localparam int NW  = 2;
   localparam int BYP = 1;
   localparam int CW  = 4;
   localparam int IW  = $clog2(NS+1);
   localparam int SAT = (1 << CW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NS-1:0]   bundle_valid_i;
   logic            issue_ready_i;
   logic            flush_i;
   logic [3*NS-1:0] rs_used_i;
   logic [18*NS-1:0] rs_addr_i;
   logic [6*NS-1:0] rd_addr_i;
   logic [NS-1:0]   rd_alu_we_i;
   logic [NS-1:0]   rd_mem_we_i;
   logic [NS-1:0]   ra_is_dst_i;
   logic [NS-1:0]   pi_legal_i;
   logic [NS-1:0]   i2_legal_i;
   logic [NW-1:0]   wb_valid_i;
   logic [6*NW-1:0] wb_addr_i;
   logic [NS-1:0]   issue_valid_o;
   logic [IW-1:0]   issue_cnt_o;
   logic [63:0]     sb_busy_o;
   logic [CW-1:0]   stall_cnt_o;

   int        n_cmp  = 0;
   int        n_fail = 0;
   bit [63:0] mbusy;
   int        mstall;
   bit        armed  = 1'b0;

   always #5 clk = ~clk;

   issue_n_alloc_scoreboard #(
      .NUM_SLOTS(NS), .NUM_WB_PORTS(NW), .WB_BYPASS(BYP), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .bundle_valid_i(bundle_valid_i),
      .issue_ready_i(issue_ready_i), .flush_i(flush_i), .rs_used_i(rs_used_i),
      .rs_addr_i(rs_addr_i), .rd_addr_i(rd_addr_i), .rd_alu_we_i(rd_alu_we_i),
      .rd_mem_we_i(rd_mem_we_i), .ra_is_dst_i(ra_is_dst_i), .pi_legal_i(pi_legal_i),
      .i2_legal_i(i2_legal_i), .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i),
      .issue_valid_o(issue_valid_o), .issue_cnt_o(issue_cnt_o),
      .sb_busy_o(sb_busy_o), .stall_cnt_o(stall_cnt_o)
   );

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic bit eff_busy(input logic [5:0] a);
      if (a == 6'd0 || !mbusy[a]) return 1'b0;
      if (BYP != 0)
         for (int p = 0; p < NW; p++)
            if (wb_valid_i[p] && wb_addr_i[6*p +: 6] == a) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit slot_writes(input int j, input logic [5:0] a);
      if (a == 6'd0) return 1'b0;
      if ((rd_alu_we_i[j] || rd_mem_we_i[j]) && rd_addr_i[6*j +: 6] == a) return 1'b1;
      if (ra_is_dst_i[j] && rs_addr_i[18*j +: 6] == a) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int model_cnt();
      bit         ok;
      logic [5:0] a;
      if (!rst_n || !issue_ready_i || flush_i) return 0;
      for (int k = 0; k < NS; k++) begin
         ok = bundle_valid_i[k] && ((k == 0) ? pi_legal_i[0] : i2_legal_i[k]);
         for (int s = 0; s < 3; s++)
            if (rs_used_i[3*k + s]) begin
               a = rs_addr_i[18*k + 6*s +: 6];
               if (eff_busy(a)) ok = 1'b0;
               for (int j = 0; j < k; j++) if (slot_writes(j, a)) ok = 1'b0;
            end
         if (rd_alu_we_i[k] || rd_mem_we_i[k]) begin
            a = rd_addr_i[6*k +: 6];
            if (eff_busy(a)) ok = 1'b0;
            for (int j = 0; j < k; j++) if (slot_writes(j, a)) ok = 1'b0;
         end
         if (ra_is_dst_i[k]) begin
            a = rs_addr_i[18*k +: 6];
            for (int j = 0; j < k; j++) if (slot_writes(j, a)) ok = 1'b0;
         end
         if (!ok) return k;
      end
      return NS;
   endfunction

   // Compare on the falling edge, then advance the model to what the next rising edge does.
   initial forever begin
      int ec;
      @(negedge clk);
      ec = model_cnt();
      if (armed) begin
         chk("issue_cnt",   64'(issue_cnt_o),   64'(ec));
         chk("issue_valid", 64'(issue_valid_o), (64'd1 << ec) - 64'd1);
         chk("sb_busy",     sb_busy_o,          mbusy);
         chk("stall_cnt",   64'(stall_cnt_o),   64'(mstall));
      end
      if (!rst_n) begin
         mbusy  = '0;
         mstall = 0;
         armed  = 1'b1;
      end else if (armed) begin
         for (int p = 0; p < NW; p++)
            if (wb_valid_i[p]) mbusy[wb_addr_i[6*p +: 6]] = 1'b0;
         for (int k = 0; k < ec; k++)
            if (rd_mem_we_i[k] && rd_addr_i[6*k +: 6] != 6'd0) mbusy[rd_addr_i[6*k +: 6]] = 1'b1;
         if (bundle_valid_i[0] && ec == 0 && !flush_i && mstall < SAT) mstall++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      bundle_valid_i = '0; issue_ready_i = 1'b1; flush_i = 1'b0;
      rs_used_i = '0; rs_addr_i = '0; rd_addr_i = '0;
      rd_alu_we_i = '0; rd_mem_we_i = '0; ra_is_dst_i = '0;
      pi_legal_i = '1; i2_legal_i = '1; wb_valid_i = '0; wb_addr_i = '0;
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic set_slot(input int k, input logic [5:0] rd, input bit alu, input bit mem,
                           input bit rad, input logic [2:0] used,
                           input logic [5:0] a, input logic [5:0] b, input logic [5:0] c);
      bundle_valid_i[k]      = 1'b1;
      rd_addr_i[6*k +: 6]    = rd;
      rd_alu_we_i[k]         = alu;
      rd_mem_we_i[k]         = mem;
      ra_is_dst_i[k]         = rad;
      rs_used_i[3*k +: 3]    = used;
      rs_addr_i[18*k +: 18]  = {c, b, a};
   endtask

   task automatic set_wb(input int p, input logic [5:0] a);
      wb_valid_i[p]        = 1'b1;
      wb_addr_i[6*p +: 6]  = a;
   endtask

   function automatic logic [5:0] pick();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 6'd0;
      if (r <= 6) return 6'(r);
      return 6'(32 + r - 7);
   endfunction

   initial begin
      rst_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);

      // lw x5 ; add x6,x5,x1 -> intra-bundle RAW stops slot 1
      cyc(); rst_n = 1'b1;
      set_slot(0, 6'd5, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
      set_slot(1, 6'd6, 1, 0, 0, 3'b011, 6'd5, 6'd1, 6'd0);
      #1 chk("raw_cnt", 64'(issue_cnt_o), 1); chk("reset_busy", sb_busy_o, 0); chk("reset_stall", 64'(stall_cnt_o), 0);

      // add x7,x5,x2 with x5 busy
      cyc(); set_slot(0, 6'd7, 1, 0, 0, 3'b011, 6'd5, 6'd2, 6'd0);
      #1 chk("lw_busy5", 64'(sb_busy_o[5]), 1); chk("busy_stall_cnt", 64'(issue_cnt_o), 0);
      cyc(); set_slot(0, 6'd7, 1, 0, 0, 3'b011, 6'd5, 6'd2, 6'd0);
      #1 chk("stall_1", 64'(stall_cnt_o), 1);
      cyc(); set_slot(0, 6'd7, 1, 0, 0, 3'b011, 6'd5, 6'd2, 6'd0); set_wb(0, 6'd5);
      #1 chk("bypass_cnt", 64'(issue_cnt_o), 1); chk("stall_2", 64'(stall_cnt_o), 2);

      // flw f3 twice; second one overlaps a write-back of f3 -> set wins
      cyc(); set_slot(0, 6'd35, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
      #1 chk("wb_clr5", 64'(sb_busy_o[5]), 0); chk("stall_hold", 64'(stall_cnt_o), 2);
         chk("flw_cnt", 64'(issue_cnt_o), 1);
      cyc(); set_slot(0, 6'd35, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0); set_wb(1, 6'd35);
      #1 chk("f3_busy", 64'(sb_busy_o[35]), 1); chk("waw_bypass_cnt", 64'(issue_cnt_o), 1);
      cyc(); set_wb(0, 6'd35);
      #1 chk("set_wins", 64'(sb_busy_o[35]), 1);

      // x0 destinations never hazard and never get tracked
      cyc(); set_slot(0, 6'd0, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
             set_slot(1, 6'd1, 1, 0, 0, 3'b011, 6'd0, 6'd0, 6'd0);
      #1 chk("f3_cleared", 64'(sb_busy_o[35]), 0); chk("x0_cnt", 64'(issue_cnt_o), 2);

      // slot 0 illegal on primary issue blocks the whole bundle
      cyc(); set_slot(0, 6'd2, 1, 0, 0, 3'b011, 6'd3, 6'd4, 6'd0);
             set_slot(1, 6'd6, 1, 0, 0, 3'b001, 6'd3, 6'd0, 6'd0); pi_legal_i = '0;
      #1 chk("x0_busy_none", sb_busy_o, 0); chk("illegal_cnt", 64'(issue_cnt_o), 0);

      // post-increment lw x8,(x9!) ; add x10,x9
      cyc(); set_slot(0, 6'd8, 0, 1, 1, 3'b001, 6'd9, 6'd0, 6'd0);
             set_slot(1, 6'd10, 1, 0, 0, 3'b001, 6'd9, 6'd0, 6'd0);
      #1 chk("postinc_cnt", 64'(issue_cnt_o), 1);

      cyc(); set_slot(0, 6'd11, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0); flush_i = 1'b1;
      #1 chk("busy8", 64'(sb_busy_o[8]), 1); chk("flush_cnt", 64'(issue_cnt_o), 0);
      cyc(); set_slot(0, 6'd11, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0); issue_ready_i = 1'b0;
      #1 chk("flush_no_set", 64'(sb_busy_o[11]), 0); chk("notready_cnt", 64'(issue_cnt_o), 0);

      cyc(); set_slot(0, 6'd12, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
             set_slot(1, 6'd13, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
      #1 chk("notready_no_set", 64'(sb_busy_o[11]), 0); chk("dual_lw_cnt", 64'(issue_cnt_o), 2);
      cyc(); set_slot(0, 6'd14, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
      #1 chk("busy_set3", sb_busy_o, 64'h3100); chk("lw14_cnt", 64'(issue_cnt_o), 1);

      // reset with several busy registers; issue reads 0 while in reset
      cyc(); rst_n = 1'b0; set_slot(0, 6'd15, 0, 1, 0, 3'b001, 6'd1, 6'd0, 6'd0);
      #1 chk("busy_set4", sb_busy_o, 64'h7100); chk("reset_gate_cnt", 64'(issue_cnt_o), 0);
      cyc(); rst_n = 1'b1; set_slot(0, 6'd2, 1, 0, 0, 3'b001, 6'd3, 6'd0, 6'd0); pi_legal_i = '0;
      #1 chk("mid_reset_busy", sb_busy_o, 0); chk("mid_reset_stall", 64'(stall_cnt_o), 0);

      // saturation of the stall counter
      for (int i = 0; i < 20; i++) begin
         cyc(); set_slot(0, 6'd2, 1, 0, 0, 3'b001, 6'd3, 6'd0, 6'd0); pi_legal_i = '0;
      end
      #1 chk("stall_sat", 64'(stall_cnt_o), SAT);

      // randomized traffic over a small register pool to provoke hazards
      for (int n = 0; n < 4000; n++) begin
         cyc();
         rst_n         = ($urandom_range(0, 149) != 0);
         issue_ready_i = ($urandom_range(0, 7) != 0);
         flush_i       = ($urandom_range(0, 15) == 0);
         for (int k = 0; k < NS; k++) begin
            if ($urandom_range(0, 3) != 0)
               set_slot(k, pick(), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                        ($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)),
                        pick(), pick(), pick());
            pi_legal_i[k] = ($urandom_range(0, 9) != 0);
            i2_legal_i[k] = ($urandom_range(0, 9) != 0);
         end
         for (int p = 0; p < NW; p++)
            if ($urandom_range(0, 2) == 0) set_wb(p, pick());
      end

      cyc();
      repeat (2) @(posedge clk);
      #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
